// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port, 1-cycle-latency memory between fetch and load/store ports.
// Optional ARB_PERF_CNT_EN adds conflict and fetch-stall cycle counters.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ADDR_BITS = 24,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [XLEN-1:0]      if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [XLEN-1:0]      if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [XLEN-1:0]      d_addr,
  input  logic [XLEN-1:0]      d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [XLEN-1:0]      d_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic [XLEN-1:0]      mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]          conflict_cnt,
  output logic [31:0]          if_stall_cnt
`endif
);

  typedef enum logic [1:0] {OwnNone, OwnIf, OwnD} owner_e;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  owner_e     resp_owner, resp_owner_d;
  logic [3:0] wait_cnt, wait_cnt_d;
  logic       fetch_wins;
  logic       unused_addr_bits;

  // Grants are forced low during reset so every output reads 0 while it is held.
  assign fetch_wins = ~reset & if_req & (~d_req | (wait_cnt == MaxWait));
  assign if_gnt     = fetch_wins;
  assign d_gnt      = ~reset & d_req & ~fetch_wins;

  assign unused_addr_bits = ^{if_addr[XLEN-1:ADDR_BITS], d_addr[XLEN-1:ADDR_BITS]};

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[ADDR_BITS-1:0];
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr[ADDR_BITS-1:0];
      mem_wdata = d_we ? d_wdata : '0;
    end
  end

  always_comb begin
    resp_owner_d = OwnNone;
    if (if_gnt) begin
      resp_owner_d = OwnIf;
    end else if (d_gnt && !d_we) begin
      resp_owner_d = OwnD;
    end

    wait_cnt_d = '0;
    if (if_req && !if_gnt) begin
      wait_cnt_d = (wait_cnt == MaxWait) ? wait_cnt : wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_owner <= OwnNone;
      wait_cnt   <= '0;
    end else begin
      resp_owner <= resp_owner_d;
      wait_cnt   <= wait_cnt_d;
    end
  end

  assign if_rvalid = (resp_owner == OwnIf);
  assign d_rvalid  = (resp_owner == OwnD);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
      if_stall_cnt <= '0;
    end else begin
      if (if_req && d_req) conflict_cnt <= conflict_cnt + 32'd1;
      if (if_req && !if_gnt) if_stall_cnt <= if_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus contention, starvation and reset sequences.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_wdata;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata;

  logic        u1_if_gnt, u1_if_rvalid, u1_d_gnt, u1_d_rvalid, u1_mem_en, u1_mem_we;
  logic [31:0] u1_if_rdata, u1_d_rdata, u1_mem_wdata;
  logic [23:0] u1_mem_addr;
  logic        unused_u1;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt, if_stall_cnt, u1_conflict_cnt, u1_if_stall_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .conflict_cnt(conflict_cnt), .if_stall_cnt(if_stall_cnt)
`endif
  );

  mem_port_arbiter #(.MAX_WAIT(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(u1_if_gnt), .if_rvalid(u1_if_rvalid),
    .if_rdata(u1_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(u1_d_gnt),
    .d_rvalid(u1_d_rvalid), .d_rdata(u1_d_rdata),
    .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr),
    .mem_wdata(u1_mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .conflict_cnt(u1_conflict_cnt), .if_stall_cnt(u1_if_stall_cnt)
`endif
  );

  assign unused_u1 = ^{u1_if_rvalid, u1_d_rvalid, u1_if_rdata, u1_d_rdata, u1_mem_we,
                       u1_mem_addr, u1_mem_wdata
`ifdef ARB_PERF_CNT_EN
                       , u1_conflict_cnt, u1_if_stall_cnt
`endif
                       };

  // Synchronous single-port memory model, word-indexed.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[13:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[13:2]];
    end
  end

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_we;
    logic [23:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_if_rv;
    logic        e_d_rv;
    logic [31:0] e_if_rd;
    logic [31:0] e_d_rd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".if_gnt"},    32'(if_gnt),    32'd0);
    check({tag, ".d_gnt"},     32'(d_gnt),     32'd0);
    check({tag, ".if_rvalid"}, 32'(if_rvalid), 32'd0);
    check({tag, ".d_rvalid"},  32'(d_rvalid),  32'd0);
    check({tag, ".if_rdata"},  if_rdata,       32'd0);
    check({tag, ".d_rdata"},   d_rdata,        32'd0);
    check({tag, ".mem_en"},    32'(mem_en),    32'd0);
    check({tag, ".mem_we"},    32'(mem_we),    32'd0);
    check({tag, ".mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, ".mem_wdata"}, mem_wdata,      32'd0);
`ifdef ARB_PERF_CNT_EN
    check({tag, ".conflict_cnt"}, conflict_cnt, 32'd0);
    check({tag, ".if_stall_cnt"}, if_stall_cnt, 32'd0);
`endif
  endtask

  // Hold if_req and d_req (data read) for n cycles, checking grants and responses.
  task automatic contend(input string tag, input int n, input logic [9:0] exp_if,
                         input logic chk_alt);
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h2000, 32'h0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s%0d.if_gnt", tag, i), 32'(if_gnt), 32'(exp_if[i]));
      check($sformatf("%s%0d.d_gnt", tag, i), 32'(d_gnt), 32'(!exp_if[i]));
      if (i > 0) begin
        check($sformatf("%s%0d.if_rvalid", tag, i), 32'(if_rvalid), 32'(exp_if[i-1]));
        check($sformatf("%s%0d.d_rvalid", tag, i), 32'(d_rvalid), 32'(!exp_if[i-1]));
        if (exp_if[i-1]) check($sformatf("%s%0d.if_rdata", tag, i), if_rdata, 32'hDEADBEEF);
        else             check($sformatf("%s%0d.d_rdata", tag, i), d_rdata, 32'h12345678);
      end
      if (chk_alt) begin
        check($sformatf("%s%0d.mw1_if_gnt", tag, i), 32'(u1_if_gnt), 32'(i % 2 == 1));
        check($sformatf("%s%0d.mw1_mem_en", tag, i), 32'(u1_mem_en), 32'd1);
      end
      tick();
    end
  endtask

  vec_t vecs[10];
  logic ifr_seq[8];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[12'h040] = 32'hDEADBEEF;
    mem_rdata = 32'h0;

    //          ifr  ifa            dr   dwe  da            dwd            igt  dgt  we   addr        wdata          irv  drv  ird            drd
    vecs[0] = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,      32'h0,         1'b1, 1'b0, 1'b0, 24'h000100, 32'h0,        1'b0, 1'b0, 32'h0,         32'h0};
    vecs[1] = '{1'b0, 32'h1234,     1'b0, 1'b0, 32'h0,      32'h0,         1'b0, 1'b0, 1'b0, 24'h0,      32'h0,        1'b1, 1'b0, 32'hDEADBEEF,  32'h0};
    vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h2000,   32'h12345678,  1'b0, 1'b1, 1'b1, 24'h002000, 32'h12345678, 1'b0, 1'b0, 32'h0,         32'h0};
    vecs[3] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h2000,   32'hFFFFFFFF,  1'b0, 1'b1, 1'b0, 24'h002000, 32'h0,        1'b0, 1'b0, 32'h0,         32'h0};
    vecs[4] = '{1'b1, 32'h0,        1'b0, 1'b0, 32'h0,      32'h0,         1'b1, 1'b0, 1'b0, 24'h0,      32'h0,        1'b0, 1'b1, 32'h0,         32'h12345678};
    vecs[5] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h4,      32'h0,         1'b0, 1'b1, 1'b0, 24'h000004, 32'h0,        1'b1, 1'b0, 32'hA0000000,  32'h0};
    vecs[6] = '{1'b1, 32'h8,        1'b0, 1'b0, 32'h0,      32'h0,         1'b1, 1'b0, 1'b0, 24'h000008, 32'h0,        1'b0, 1'b1, 32'h0,         32'hA0000001};
    vecs[7] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h3000,   32'h55AA55AA,  1'b0, 1'b0, 1'b0, 24'h0,      32'h0,        1'b1, 1'b0, 32'hA0000002,  32'h0};
    vecs[8] = '{1'b1, 32'hFF000100, 1'b0, 1'b0, 32'h0,      32'h0,         1'b1, 1'b0, 1'b0, 24'h000100, 32'h0,        1'b0, 1'b0, 32'h0,         32'h0};
    vecs[9] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,      32'h0,         1'b0, 1'b0, 1'b0, 24'h0,      32'h0,        1'b1, 1'b0, 32'hDEADBEEF,  32'h0};

    // Reset with requests active: all outputs must stay 0.
    reset = 1'b1;
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h2000, 32'hCAFEF00D);
    tick();
    tick();
    check_all_zero("por");
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("por_rel.if_rvalid", 32'(if_rvalid), 32'd0);
    check("por_rel.d_rvalid", 32'(d_rvalid), 32'd0);
    tick();

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].ifr, vecs[i].ifa, vecs[i].dr, vecs[i].dwe, vecs[i].da, vecs[i].dwd);
      @(negedge clk);
      check($sformatf("v%0d.if_gnt", i),    32'(if_gnt),    32'(vecs[i].e_if_gnt));
      check($sformatf("v%0d.d_gnt", i),     32'(d_gnt),     32'(vecs[i].e_d_gnt));
      check($sformatf("v%0d.mem_en", i),    32'(mem_en),    32'(vecs[i].e_if_gnt | vecs[i].e_d_gnt));
      check($sformatf("v%0d.mem_we", i),    32'(mem_we),    32'(vecs[i].e_we));
      check($sformatf("v%0d.mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_addr));
      check($sformatf("v%0d.mem_wdata", i), mem_wdata,      vecs[i].e_wdata);
      check($sformatf("v%0d.if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].e_if_rv));
      check($sformatf("v%0d.d_rvalid", i),  32'(d_rvalid),  32'(vecs[i].e_d_rv));
      check($sformatf("v%0d.if_rdata", i),  if_rdata,       vecs[i].e_if_rd);
      check($sformatf("v%0d.d_rdata", i),   d_rdata,        vecs[i].e_d_rd);
      tick();
    end

    // Ten cycles of contention: d,d,d,d,if,d,d,d,d,if (bit i = fetch wins in cycle i).
    contend("ct", 10, 10'b10000_10000, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("ct_tail.if_rvalid", 32'(if_rvalid), 32'd1);
    check("ct_tail.d_rvalid", 32'(d_rvalid), 32'd0);
    check("ct_tail.if_rdata", if_rdata, 32'hDEADBEEF);
`ifdef ARB_PERF_CNT_EN
    check("perf.conflict_cnt", conflict_cnt, 32'd10);
    check("perf.if_stall_cnt", if_stall_cnt, 32'd8);
`endif
    tick();

    // Fetch drops its request mid-wait, then re-requests; address changes on the winning cycle.
    ifr_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive(ifr_seq[i], (i == 7) ? 32'h8 : 32'h100, 1'b1, 1'b0, 32'h4, 32'h0);
      @(negedge clk);
      check($sformatf("drop%0d.if_gnt", i), 32'(if_gnt), 32'(i == 7));
      if (i == 7) check("drop7.mem_addr", 32'(mem_addr), 32'h8);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("drop_tail.if_rdata", if_rdata, 32'hA0000002);
    tick();

    // Reset with a fetch read in flight.
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rst1.if_gnt", 32'(if_gnt), 32'd1);
    tick();
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h2000, 32'h11111111);
    reset = 1'b1;
    #1;
    check_all_zero("rst1");
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("rst1_rel%0d.if_rvalid", i), 32'(if_rvalid), 32'd0);
      check($sformatf("rst1_rel%0d.d_rvalid", i), 32'(d_rvalid), 32'd0);
      tick();
    end

    // Reset while the starvation counter is non-zero and a data read is in flight.
    contend("pre", 3, 10'b0, 1'b0);
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rst2.d_rvalid", 32'(d_rvalid), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst2_rel.d_rvalid", 32'(d_rvalid), 32'd0);
    tick();
    contend("post", 5, 10'b00000_10000, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, 1-cycle-latency synchronous memory between the hart's instruction-fetch port and its load/store port.
- Sits between Hart and a unified memory. It replaces the separate instruction and data memories once the core moves to a single memory.
- Policy: the data port has priority, with a bounded-wait starvation guard for fetch.
- Fully pipelined: one access can be issued every cycle.

Parameters:
- XLEN, 32, width of addresses and data words
- ADDR_BITS, 24, memory byte-address width; mem_addr = addr[ADDR_BITS-1:0]
- MAX_WAIT, 4, consecutive denied fetch cycles after which fetch wins over data; legal range 1..15

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  XLEN  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  XLEN  fetch read data
- d_req  in  1  data request; held stable until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid
- d_rdata  out  XLEN  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_BITS  memory address
- mem_wdata  out  XLEN  memory write data
- mem_rdata  in  XLEN  memory read data, valid the cycle after a read issue

Behaviour:
- Reset: clk and reset as named; reset is asynchronous, active-high.
  - All state clears: wait_cnt=0, resp_owner=NONE.
  - While reset is high, every output is 0.
- Grant (combinational from current requests and registered state):
  - fetch_wins = if_req & (~d_req | wait_cnt==MAX_WAIT)
  - if_gnt = fetch_wins
  - d_gnt = d_req & ~fetch_wins
  - At most one grant per cycle.
- Memory drive:
  - mem_en = if_gnt | d_gnt.
  - mem_we = d_gnt & d_we.
  - mem_addr and mem_wdata come from the granted port.
  - With no grant, mem_addr and mem_wdata are 0.
  - mem_wdata is 0 on reads.
- Response tracking: register resp_owner ∈ {NONE, IF, D}, updated every cycle.
  - IF if if_gnt.
  - D if d_gnt & ~d_we.
  - Else NONE.
- Read response (latency exactly 1 cycle after grant):
  - if_rvalid = (resp_owner==IF); d_rvalid = (resp_owner==D).
  - *_rdata = mem_rdata when the matching rvalid is high, else 0.
- Writes complete at d_gnt and never produce d_rvalid.
- Back-to-back grants are allowed every cycle. A response and a new grant may occur in the same cycle.
- Starvation counter wait_cnt (4 bits):
  - if_req & ~if_gnt: increments, saturating at MAX_WAIT.
  - if_gnt or ~if_req: clears to 0.
- Boundaries:
  - A requester dropping req before grant is legal; no state is retained for it.
  - A request address change while waiting takes effect at grant.
  - Reset asserted with a read in flight: the response is discarded, and no rvalid appears after reset release.
  - MAX_WAIT=1: under continuous contention, grants strictly alternate d, if, d, if...

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, adds outputs:
  - conflict_cnt (32): counts cycles with if_req & d_req.
  - if_stall_cnt (32): counts cycles with if_req & ~if_gnt.
- Both counters wrap modulo 2^32 and are cleared by reset.
- When undefined, neither the ports nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- Fetch read alone: if_req=1, if_addr=0x100, mem holds 0xDEADBEEF at 0x100 -> same cycle if_gnt=1, mem_en=1, mem_we=0, mem_addr=0x100; next cycle if_rvalid=1, if_rdata=0xDEADBEEF; d_rvalid=0 throughout.
- Data write then read: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0x12345678 -> d_gnt=1, mem_we=1, no d_rvalid. Next cycle d_we=0, same address -> d_gnt=1; one cycle later d_rvalid=1, d_rdata=0x12345678.
- Contention, MAX_WAIT=4: if_req and d_req held high for 10 cycles -> grants d,d,d,d,if,d,d,d,d,if. Every rvalid lands one cycle after its own grant on the correct port only.
- Pipelined alternation: fetch 0x0, data-read 0x4, fetch 0x8 in consecutive cycles -> if_rvalid, d_rvalid, if_rvalid on the three following consecutive cycles, with matching data.
- Reset mid-flight: grant a fetch read, assert reset the next cycle before the clock edge -> all outputs 0 immediately. After release with no requests, no rvalid appears and wait_cnt=0.
- ARB_PERF_CNT_EN: run the 10-cycle contention scenario -> conflict_cnt=10, if_stall_cnt=8. Reset -> both counters read 0.
